store_sequencer: RTL and testbench
==================================

STORE_SEQUENCER -- requirements
Module: store_sequencer

Interface
REQ-001 SHALL have ports: clk  input  1  single clock; all state changes on its rising edge.
REQ-002 SHALL have: reset_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have: start  input  1  store request; sampled only in IDLE.
REQ-004 SHALL have: store_type  input  2  01=sw, 10=sh, 11=sb, 00=illegal.
REQ-005 SHALL have: addr  input  32  word address of the store target.
REQ-006 SHALL have: b_data  input  32  register-B store operand.
REQ-007 SHALL have: mem_rdata  input  32  memory read data, valid one cycle after the address is presented.
REQ-008 SHALL have: mem_addr  output  32  memory address.
REQ-009 SHALL have: mem_wr  output  1  memory write strobe, one cycle per store.
REQ-010 SHALL have: mem_wdata  output  32  merged write word.
REQ-011 SHALL have: busy  output  1  high in every state except IDLE.
REQ-012 SHALL have: done  output  1  one-cycle completion pulse.
REQ-013 SHALL have: err  output  1  one-cycle pulse, coincident with done, for illegal store_type.

Function
REQ-014 SHALL implement states IDLE, RD, WAIT, WR, DONE.
REQ-015 In IDLE with start=1, SHALL capture addr, b_data and store_type into internal registers; later input changes have no effect.
REQ-016 Transitions: IDLE->WR for sw; IDLE->RD for sh/sb; IDLE->DONE with err for 00; RD->WAIT; WAIT->WR; WR->DONE; DONE->IDLE.
REQ-017 In RD and WAIT, SHALL drive mem_addr=captured addr and mem_wr=0.
REQ-018 At the clock edge leaving WAIT, SHALL capture mem_rdata into an internal 32-bit data register (mdr).
REQ-019 In WR, SHALL drive mem_wr=1, mem_addr=captured addr, and mem_wdata as follows:
  - sw: b_data
  - sh: {mdr[31:16], b_data[15:0]}
  - sb: {mdr[31:8], b_data[7:0]}
REQ-020 Outside WR, mem_wr SHALL be 0 and mem_wdata SHALL be 0.
REQ-021 Outside RD/WAIT/WR, mem_addr SHALL be 0.
REQ-022 Latency from the start edge: sw shows mem_wr in cycle 1 and done in cycle 2; sh/sb show mem_wr in cycle 3 and done in cycle 4; illegal type shows done+err in cycle 1.
REQ-023 done SHALL be high only in DONE; start asserted in DONE or any busy state SHALL be ignored, not queued.
REQ-024 A start in the first IDLE cycle after DONE SHALL be accepted, giving back-to-back throughput of one store per 3 (sw) or 5 (sh/sb) cycles.
REQ-025 Exactly one mem_wr pulse SHALL occur per legal store; no write SHALL occur for an illegal store.
REQ-026 All outputs SHALL be decoded from registered state and captured operands only, with no combinational path from inputs to outputs.

Reset
REQ-027 reset_n low SHALL immediately force IDLE and clear captured registers and mdr to 0, and force busy, done, err, mem_wr, mem_addr and mem_wdata to 0, regardless of clock.
REQ-028 Reset asserted mid-operation (any of RD/WAIT/WR/DONE) SHALL abort the operation without a write or done pulse; after release, the block SHALL wait in IDLE for a new start.

Verification
REQ-029 Test sw: start, type=01, addr=0x10, b_data=0xDEADBEEF -> cycle 1: mem_wr=1, mem_addr=0x10, mem_wdata=0xDEADBEEF; cycle 2: done=1.
REQ-030 Test sh: type=10, b_data=0x0000ABCD, memory word=0x11223344 -> cycle 3: mem_wdata=0x1122ABCD, mem_wr=1; cycle 4: done=1.
REQ-031 Test sb: type=11, b_data=0xFFFFFF5A, memory word=0x11223344 -> mem_wdata=0x1122335A, with exactly one mem_wr pulse.
REQ-032 Test illegal type: start with type=00 -> cycle 1: done=1 and err=1; mem_wr stays 0 throughout.
REQ-033 Test start during busy and back-to-back starts: a second start during an sh op is ignored; a start held high through DONE is accepted on the next IDLE cycle.
REQ-034 Test reset during WAIT of an sb op: mem_wr never pulses, all outputs go to 0 asynchronously, and a following sw completes normally.

Source files
------------

// File: rtl/store_sequencer_if.sv
// Bus bundle for store_sequencer: store request, operands and the memory port.
interface store_sequencer_if;
  logic        start;
  logic [1:0]  store_type;
  logic [31:0] addr;
  logic [31:0] b_data;
  logic [31:0] mem_rdata;
  logic [31:0] mem_addr;
  logic        mem_wr;
  logic [31:0] mem_wdata;
  logic        busy;
  logic        done;
  logic        err;

  modport master (
    output start, store_type, addr, b_data, mem_rdata,
    input  mem_addr, mem_wr, mem_wdata, busy, done, err
  );

  modport slave (
    input  start, store_type, addr, b_data, mem_rdata,
    output mem_addr, mem_wr, mem_wdata, busy, done, err
  );
endinterface

// File: rtl/store_sequencer.sv
// Store sequencer: word stores write directly; half/byte stores read-modify-write
// the target word through a one-cycle-latency memory port.
module store_sequencer (
  input  logic              clk,
  input  logic              reset_n,
  store_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    WAIT = 3'd2,
    WR   = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam logic [1:0] TYPE_SW = 2'b01;
  localparam logic [1:0] TYPE_SH = 2'b10;
  localparam logic [1:0] TYPE_SB = 2'b11;

  state_t      state, state_nxt;
  logic [1:0]  type_q;
  logic [31:0] addr_q;
  logic [31:0] data_q;
  logic [31:0] mdr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      type_q <= '0;
      addr_q <= '0;
      data_q <= '0;
      mdr    <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && bus.start) begin
        type_q <= bus.store_type;
        addr_q <= bus.addr;
        data_q <= bus.b_data;
      end
      // Read data arrives the cycle after RD presents the address.
      if (state == WAIT) begin
        mdr <= bus.mem_rdata;
      end
    end
  end

  // Outputs depend only on state and captured registers, never on live inputs.
  always_comb begin
    state_nxt     = state;
    bus.busy      = 1'b1;
    bus.done      = 1'b0;
    bus.err       = 1'b0;
    bus.mem_wr    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    case (state)
      IDLE: begin
        bus.busy = 1'b0;
        if (bus.start) begin
          case (bus.store_type)
            TYPE_SW:          state_nxt = WR;
            TYPE_SH, TYPE_SB: state_nxt = RD;
            default:          state_nxt = DONE;
          endcase
        end
      end
      RD: begin
        bus.mem_addr = addr_q;
        state_nxt    = WAIT;
      end
      WAIT: begin
        bus.mem_addr = addr_q;
        state_nxt    = WR;
      end
      WR: begin
        bus.mem_wr   = 1'b1;
        bus.mem_addr = addr_q;
        case (type_q)
          TYPE_SH: bus.mem_wdata = {mdr[31:16], data_q[15:0]};
          TYPE_SB: bus.mem_wdata = {mdr[31:8], data_q[7:0]};
          default: bus.mem_wdata = data_q;
        endcase
        state_nxt = DONE;
      end
      DONE: begin
        bus.done  = 1'b1;
        bus.err   = (type_q == 2'b00);
        state_nxt = IDLE;
      end
      default: begin
        bus.busy  = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_store_sequencer.sv
// Randomized self-checking bench for store_sequencer against a transaction-level
// model of latency, write merging and memory contents.
module tb_store_sequencer;

  logic clk;
  logic reset_n;
  store_sequencer_if bus ();

  store_sequencer dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [16];
  logic [31:0] ref_mem [16];
  int          wr_count = 0;
  logic        pre_en;
  logic [3:0]  pre_idx;
  logic [31:0] pre_val;

  // Memory with one cycle of read latency; preload port used only while idle.
  always @(posedge clk) begin
    if (pre_en) begin
      mem[pre_idx] <= pre_val;
    end else if (bus.mem_wr) begin
      mem[bus.mem_addr[3:0]] <= bus.mem_wdata;
      wr_count <= wr_count + 1;
    end
    bus.mem_rdata <= mem[bus.mem_addr[3:0]];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [1:0] t, input logic [31:0] m,
                                        input logic [31:0] b);
    case (t)
      2'b01:   return b;
      2'b10:   return {m[31:16], b[15:0]};
      2'b11:   return {m[31:8], b[7:0]};
      default: return 32'h0;
    endcase
  endfunction

  task automatic preload(input logic [3:0] idx, input logic [31:0] val);
    bus.start = 1'b0;
    pre_en  = 1'b1;
    pre_idx = idx;
    pre_val = val;
    ref_mem[idx] = val;
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  // Called at the negedge of an IDLE cycle; returns at the negedge of the DONE cycle + 1.
  task automatic run_op(input logic [1:0] t, input logic [31:0] a, input logic [31:0] b,
                        input bit hold_start);
    bit          legal;
    int          lat_wr, total, wr0;
    logic [31:0] exp_w;
    legal  = (t != 2'b00);
    lat_wr = (t == 2'b01) ? 1 : 3;
    total  = legal ? lat_wr + 1 : 1;
    exp_w  = merge(t, ref_mem[a[3:0]], b);
    wr0    = wr_count;
    check("idle_busy", {31'b0, bus.busy}, 32'd0);
    bus.start      = 1'b1;
    bus.store_type = t;
    bus.addr       = a;
    bus.b_data     = b;
    for (int k = 1; k <= total; k++) begin
      @(negedge clk);
      check("busy", {31'b0, bus.busy}, 32'd1);
      check("mem_wr", {31'b0, bus.mem_wr}, {31'b0, legal && k == lat_wr});
      check("mem_addr", bus.mem_addr, (legal && k <= lat_wr) ? a : 32'h0);
      check("mem_wdata", bus.mem_wdata, (legal && k == lat_wr) ? exp_w : 32'h0);
      check("done", {31'b0, bus.done}, {31'b0, k == total});
      check("err", {31'b0, bus.err}, {31'b0, k == total && !legal});
      // Scramble inputs while busy: the captured operands must be the ones used.
      bus.start      = (k == total) ? hold_start : 1'($urandom_range(0, 1));
      bus.store_type = 2'($urandom);
      bus.addr       = $urandom;
      bus.b_data     = $urandom;
    end
    @(negedge clk);
    check("write_count", wr_count - wr0, legal ? 1 : 0);
    if (legal) ref_mem[a[3:0]] = exp_w;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, {31'b0, bus.busy}, 32'd0);
    check({tag, "_done"}, {31'b0, bus.done}, 32'd0);
    check({tag, "_err"}, {31'b0, bus.err}, 32'd0);
    check({tag, "_mem_wr"}, {31'b0, bus.mem_wr}, 32'd0);
    check({tag, "_mem_addr"}, bus.mem_addr, 32'h0);
    check({tag, "_mem_wdata"}, bus.mem_wdata, 32'h0);
  endtask

  task automatic reset_during_wait();
    int wr0;
    logic [31:0] a;
    a   = 32'h0000_0037;
    wr0 = wr_count;
    bus.start      = 1'b1;
    bus.store_type = 2'b11;
    bus.addr       = a;
    bus.b_data     = 32'h0000_00C3;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    check("rst_wait_addr", bus.mem_addr, a);
    #2 reset_n = 1'b0;
    #1 check_all_zero("rst_async");
    @(negedge clk);
    check_all_zero("rst_hold");
    reset_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_all_zero("rst_after");
    check("rst_no_write", wr_count - wr0, 0);
  endtask

  initial begin
    bus.start      = 1'b0;
    bus.store_type = 2'b00;
    bus.addr       = '0;
    bus.b_data     = '0;
    pre_en         = 1'b0;
    pre_idx        = '0;
    pre_val        = '0;
    reset_n        = 1'b1;
    #1 reset_n = 1'b0;
    #1 check_all_zero("reset");
    for (int i = 0; i < 16; i++) preload(4'(i), $urandom);
    check_all_zero("reset_held");
    reset_n = 1'b1;
    @(negedge clk);

    // Directed stores from the worked examples.
    run_op(2'b01, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0);
    bus.start = 1'b0;
    preload(4'h4, 32'h1122_3344);
    run_op(2'b10, 32'h0000_0024, 32'h0000_ABCD, 1'b0);
    bus.start = 1'b0;
    preload(4'h5, 32'h1122_3344);
    run_op(2'b11, 32'h0000_0035, 32'hFFFF_FF5A, 1'b0);
    bus.start = 1'b0;
    @(negedge clk);
    check("sb_result", mem[5], 32'h1122_335A);
    check("sh_result", mem[4], 32'h1122_ABCD);
    run_op(2'b00, 32'h0000_0011, 32'h1234_5678, 1'b0);
    bus.start = 1'b0;
    @(negedge clk);

    // Back-to-back: start held through DONE is taken in the next IDLE cycle.
    run_op(2'b10, 32'h0000_0046, 32'h5555_7777, 1'b1);
    run_op(2'b01, 32'h0000_0047, 32'h0BAD_F00D, 1'b1);
    run_op(2'b11, 32'h0000_0046, 32'h0000_0099, 1'b0);
    bus.start = 1'b0;
    @(negedge clk);

    reset_during_wait();
    run_op(2'b01, 32'h0000_0018, 32'hCAFE_0001, 1'b0);
    bus.start = 1'b0;
    @(negedge clk);

    for (int n = 0; n < 200; n++) begin
      bit hold;
      hold = 1'($urandom_range(0, 1));
      run_op(2'($urandom), $urandom, $urandom, hold);
      if (!hold) begin
        bus.start = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    end
    bus.start = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 16; i++) check("final_mem", mem[i], ref_mem[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
